// File: rtl/drp_if.sv
// DRP access bus between a configuration master and the register bank.
// The slave side returns read data, the completion pulse and the busy/error handshake.
interface drp_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic        derr;
  logic        busy;

  modport master (
    output daddr,
    output den,
    output dwe,
    output di,
    input  dout,
    input  drdy,
    input  derr,
    input  busy
  );

  modport slave (
    input  daddr,
    input  den,
    input  dwe,
    input  di,
    output dout,
    output drdy,
    output derr,
    output busy
  );
endinterface

// File: rtl/drp_reg_bank.sv
// DRP register bank for the PLL model: clock-output, feedback, divider, lock, filter and
// power registers behind a latency-programmable DRP port, with divide/duty decode.
module drp_reg_bank #(
  parameter int unsigned NUM_CLKOUT  = 7,
  parameter int unsigned RDY_LATENCY = 1
) (
  input  logic                    dclk,
  input  logic                    rst,
  input  logic                    pwrdwn,
  drp_if.slave                    drp,
  output logic                    cfg_update,
  output logic [7*NUM_CLKOUT-1:0] clkout_divide,
  output logic [NUM_CLKOUT-1:0]   clkout_half,
  output logic [6:0]              clkfbout_mult,
  output logic [6:0]              divclk_divide
);

  localparam logic [3:0] CntLoad = 4'(RDY_LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        accept, commit, wr, busy;

  logic [15:0] reg1_q [NUM_CLKOUT];
  logic [15:0] reg2_q [NUM_CLKOUT];
  logic [15:0] fb1_q, fb2_q, div_q, power_q;
  logic [15:0] lock_q [3];
  logic [15:0] filt_q [2];
  logic [15:0] do_q, rd_data;
  logic        derr_q, cfg_update_q;

  logic        ch_valid, ch_hit, fb_hit, div_hit, lock_hit, pwr_hit, filt_hit, mapped;
  logic [2:0]  ch_idx;

  // A zero HIGH/LOW field counts as 64; the 7-bit sum wraps so divide 128 reads as 0.
  function automatic logic [6:0] div_calc(input logic [5:0] hi, input logic [5:0] lo,
                                          input logic nc);
    logic [6:0] h, l;
    h = (hi == 6'd0) ? 7'd64 : {1'b0, hi};
    l = (lo == 6'd0) ? 7'd64 : {1'b0, lo};
    return nc ? 7'd1 : 7'(h + l);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    if (pwrdwn) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: accept = drp.den;
        StWait: begin
          if (cnt_q == 4'd0) begin
            commit = 1'b1;
            accept = drp.den;
            if (!drp.den) state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (accept) begin
        state_d = StWait;
        cnt_d   = CntLoad;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= drp.daddr;
        we_q    <= drp.dwe;
        wdata_q <= drp.di;
      end
    end
  end

  // Channel pairs are not contiguous: CLKOUT5 sits below CLKOUT0, CLKOUT6 above CLKOUT4.
  always_comb begin
    ch_valid = 1'b1;
    ch_idx   = 3'd0;
    unique case (addr_q[6:1])
      6'h03:   ch_idx = 3'd5;
      6'h04:   ch_idx = 3'd0;
      6'h05:   ch_idx = 3'd1;
      6'h06:   ch_idx = 3'd2;
      6'h07:   ch_idx = 3'd3;
      6'h08:   ch_idx = 3'd4;
      6'h09:   ch_idx = 3'd6;
      default: ch_valid = 1'b0;
    endcase
  end

  assign ch_hit   = ch_valid && (32'(ch_idx) < NUM_CLKOUT);
  assign fb_hit   = (addr_q[6:1] == 6'h0A);
  assign div_hit  = (addr_q == 7'h16);
  assign lock_hit = (addr_q == 7'h18) || (addr_q == 7'h19) || (addr_q == 7'h1A);
  assign pwr_hit  = (addr_q == 7'h28);
  assign filt_hit = (addr_q[6:1] == 6'h27);
  assign mapped   = ch_hit || fb_hit || div_hit || lock_hit || pwr_hit || filt_hit;
  assign wr       = commit && we_q;

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(NUM_CLKOUT); k++) begin
      if (ch_hit && ch_idx == 3'(k)) rd_data = addr_q[0] ? reg2_q[k] : reg1_q[k];
    end
    for (int i = 0; i < 3; i++) begin
      if (lock_hit && addr_q[1:0] == 2'(i)) rd_data = lock_q[i];
    end
    if (fb_hit)   rd_data = addr_q[0] ? fb2_q : fb1_q;
    if (div_hit)  rd_data = div_q;
    if (pwr_hit)  rd_data = power_q;
    if (filt_hit) rd_data = filt_q[addr_q[0]];
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_CLKOUT); k++) begin
        reg1_q[k] <= 16'h0041;
        reg2_q[k] <= '0;
      end
      for (int i = 0; i < 3; i++) lock_q[i] <= '0;
      filt_q[0]    <= '0;
      filt_q[1]    <= '0;
      fb1_q        <= 16'h0041;
      fb2_q        <= '0;
      div_q        <= 16'h1041;
      power_q      <= '0;
      do_q         <= '0;
      derr_q       <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= wr && mapped;
      derr_q       <= drp.den && (pwrdwn || busy);
      if (commit && !we_q) do_q <= rd_data;
      if (wr) begin
        for (int k = 0; k < int'(NUM_CLKOUT); k++) begin
          if (ch_hit && ch_idx == 3'(k)) begin
            if (addr_q[0]) reg2_q[k] <= wdata_q;
            else           reg1_q[k] <= wdata_q;
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (lock_hit && addr_q[1:0] == 2'(i)) lock_q[i] <= wdata_q;
        end
        if (fb_hit && !addr_q[0]) fb1_q <= wdata_q;
        if (fb_hit && addr_q[0])  fb2_q <= wdata_q;
        if (div_hit)              div_q <= wdata_q;
        if (pwr_hit)              power_q <= wdata_q;
        if (filt_hit)             filt_q[addr_q[0]] <= wdata_q;
      end
    end
  end

  // Completion is visible in the cycle the counter reaches zero, so read data bypasses do_q.
  assign busy     = (state_q == StWait) && (cnt_q != 4'd0);
  assign drp.busy = busy;
  assign drp.drdy = commit && !rst;
  assign drp.dout = (drp.drdy && !we_q) ? rd_data : do_q;
  assign drp.derr = derr_q;
  assign cfg_update = cfg_update_q;

  for (genvar k = 0; k < int'(NUM_CLKOUT); k++) begin : g_ch
    assign clkout_divide[7*k +: 7] = div_calc(reg1_q[k][11:6], reg1_q[k][5:0], reg2_q[k][6]);
    assign clkout_half[k]          = reg2_q[k][7];
  end

  assign clkfbout_mult = div_calc(fb1_q[11:6], fb1_q[5:0], fb2_q[6]);
  assign divclk_divide = div_calc(div_q[11:6], div_q[5:0], div_q[12]);

endmodule
